// File: rtl/udp_tx_arbiter_pkg.sv
// ============================================================================
// udp_tx_arbiter_pkg : shared FSM encoding, field widths and defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package udp_tx_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HDR     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    localparam int IP_W   = 32;
    localparam int PORT_W = 16;
    localparam int LEN_W  = 16;
    localparam int GNT_W  = 2;

    localparam logic [7:0] DEFAULT_TTL = 8'd64;

endpackage

`default_nettype wire

// File: rtl/udp_rr_arbiter.sv
// ============================================================================
// udp_rr_arbiter : combinational rotate-priority picker, search starts at ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module udp_rr_arbiter
    import udp_tx_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req,
    input  logic [GNT_W-1:0] ptr,
    output logic [GNT_W-1:0] gnt_idx,
    output logic             gnt_any
);

    int w_pos;

    // Walk offsets from far to near so the request closest to ptr wins last.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        w_pos   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = (int'(ptr) + k) % N;
            if (req[w_pos]) begin
                gnt_idx = GNT_W'(w_pos);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/udp_tx_arbiter.sv
// ============================================================================
// udp_tx_arbiter : round-robin, whole-frame sharing of the udp_core TX port
// Rev 1.0
// ============================================================================
`default_nettype none

module udp_tx_arbiter
    import udp_tx_arbiter_pkg::*;
#(
    parameter int         N      = 2,
    parameter logic [7:0] IP_TTL = DEFAULT_TTL
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IP_W-1:0]     local_ip,

    input  logic [N-1:0]        s_hdr_valid,
    output logic [N-1:0]        s_hdr_ready,
    input  logic [N*IP_W-1:0]   s_dest_ip,
    input  logic [N*PORT_W-1:0] s_source_port,
    input  logic [N*PORT_W-1:0] s_dest_port,
    input  logic [N*LEN_W-1:0]  s_length,
    input  logic [N*8-1:0]      s_tdata,
    input  logic [N-1:0]        s_tvalid,
    input  logic [N-1:0]        s_tlast,
    input  logic [N-1:0]        s_tuser,
    output logic [N-1:0]        s_tready,

    output logic                m_hdr_valid,
    input  logic                m_hdr_ready,
    output logic [5:0]          m_ip_dscp,
    output logic [1:0]          m_ip_ecn,
    output logic [7:0]          m_ip_ttl,
    output logic [IP_W-1:0]     m_ip_source_ip,
    output logic [IP_W-1:0]     m_ip_dest_ip,
    output logic [PORT_W-1:0]   m_source_port,
    output logic [PORT_W-1:0]   m_dest_port,
    output logic [LEN_W-1:0]    m_length,
    output logic [15:0]         m_checksum,
    output logic [7:0]          m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast,
    output logic                m_tuser,

    output logic [GNT_W-1:0]    grant,
    output logic                busy
);

    logic [1:0]        r_state;
    logic [GNT_W-1:0]  r_ptr;
    logic [GNT_W-1:0]  r_grant;
    logic              r_hdr_valid;
    logic [IP_W-1:0]   r_dest_ip;
    logic [PORT_W-1:0] r_source_port;
    logic [PORT_W-1:0] r_dest_port;
    logic [LEN_W-1:0]  r_length;

    logic [IP_W-1:0]   w_dest_ip     [4];
    logic [PORT_W-1:0] w_source_port [4];
    logic [PORT_W-1:0] w_dest_port   [4];
    logic [LEN_W-1:0]  w_length      [4];
    logic [7:0]        w_tdata       [4];
    logic [3:0]        w_tvalid;
    logic [3:0]        w_tlast;
    logic [3:0]        w_tuser;
    logic [3:0]        w_hdr_ready;
    logic [3:0]        w_tready;
    logic [GNT_W-1:0]  w_gnt_idx;
    logic              w_gnt_any;
    logic              w_in_idle;
    logic              w_in_payload;
    logic              w_last_beat;

    // Unpack into fixed 4-entry arrays so a 2-bit grant can index any N.
    for (genvar i = 0; i < 4; i++) begin : g_src
        if (i < N) begin : g_used
            assign w_dest_ip[i]     = s_dest_ip[i*IP_W +: IP_W];
            assign w_source_port[i] = s_source_port[i*PORT_W +: PORT_W];
            assign w_dest_port[i]   = s_dest_port[i*PORT_W +: PORT_W];
            assign w_length[i]      = s_length[i*LEN_W +: LEN_W];
            assign w_tdata[i]       = s_tdata[i*8 +: 8];
            assign w_tvalid[i]      = s_tvalid[i];
            assign w_tlast[i]       = s_tlast[i];
            assign w_tuser[i]       = s_tuser[i];
        end else begin : g_pad
            assign w_dest_ip[i]     = '0;
            assign w_source_port[i] = '0;
            assign w_dest_port[i]   = '0;
            assign w_length[i]      = '0;
            assign w_tdata[i]       = '0;
            assign w_tvalid[i]      = 1'b0;
            assign w_tlast[i]       = 1'b0;
            assign w_tuser[i]       = 1'b0;
        end
    end

    udp_rr_arbiter #(
        .N       (N)
    ) u_rr (
        .req     (s_hdr_valid),
        .ptr     (r_ptr),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    assign w_in_idle    = (r_state == ST_IDLE);
    assign w_in_payload = (r_state == ST_PAYLOAD);

    always_comb begin
        w_hdr_ready = '0;
        w_tready    = '0;
        if (w_in_idle && w_gnt_any) begin
            w_hdr_ready[w_gnt_idx] = 1'b1;
        end
        if (w_in_payload) begin
            w_tready[r_grant] = m_tready;
        end
    end

    assign s_hdr_ready = w_hdr_ready[N-1:0];
    assign s_tready    = w_tready[N-1:0];

    assign m_tdata     = w_tdata[r_grant];
    assign m_tvalid    = w_in_payload & w_tvalid[r_grant];
    assign m_tlast     = w_tlast[r_grant];
    assign m_tuser     = w_tuser[r_grant];
    assign w_last_beat = m_tvalid & m_tready & m_tlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_grant       <= '0;
            r_hdr_valid   <= 1'b0;
            r_dest_ip     <= '0;
            r_source_port <= '0;
            r_dest_port   <= '0;
            r_length      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_any) begin
                        r_dest_ip     <= w_dest_ip[w_gnt_idx];
                        r_source_port <= w_source_port[w_gnt_idx];
                        r_dest_port   <= w_dest_port[w_gnt_idx];
                        r_length      <= w_length[w_gnt_idx];
                        r_grant       <= w_gnt_idx;
                        r_hdr_valid   <= 1'b1;
                        r_state       <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (m_hdr_ready) begin
                        r_hdr_valid <= 1'b0;
                        r_state     <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_last_beat) begin
                        r_ptr   <= (r_grant == GNT_W'(N - 1)) ? '0 : r_grant + 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m_hdr_valid    = r_hdr_valid;
    assign m_ip_dscp      = '0;
    assign m_ip_ecn       = '0;
    assign m_ip_ttl       = IP_TTL;
    assign m_checksum     = '0;
    assign m_ip_source_ip = local_ip;
    assign m_ip_dest_ip   = r_dest_ip;
    assign m_source_port  = r_source_port;
    assign m_dest_port    = r_dest_port;
    assign m_length       = r_length;
    assign grant          = r_grant;
    assign busy           = ~w_in_idle;

endmodule

`default_nettype wire

// File: tb/tb_udp_tx_arbiter.sv
// ============================================================================
// tb_udp_tx_arbiter : directed self-checking bench for udp_tx_arbiter (N=2)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_udp_tx_arbiter;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   local_ip = 32'hC0A80164;
    logic [N-1:0]  s_hdr_valid, s_hdr_ready, s_tvalid, s_tlast, s_tuser, s_tready;
    logic [N*32-1:0] s_dest_ip;
    logic [N*16-1:0] s_source_port, s_dest_port, s_length;
    logic [N*8-1:0]  s_tdata;
    logic          m_hdr_valid, m_hdr_ready;
    logic [5:0]    m_ip_dscp;
    logic [1:0]    m_ip_ecn;
    logic [7:0]    m_ip_ttl;
    logic [31:0]   m_ip_source_ip, m_ip_dest_ip;
    logic [15:0]   m_source_port, m_dest_port, m_length, m_checksum;
    logic [7:0]    m_tdata;
    logic          m_tvalid, m_tready, m_tlast, m_tuser;
    logic [1:0]    grant;
    logic          busy;

    udp_tx_arbiter #(.N(N), .IP_TTL(8'd64)) dut (
        .clk(clk), .rst(rst), .local_ip(local_ip),
        .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
        .s_dest_ip(s_dest_ip), .s_source_port(s_source_port),
        .s_dest_port(s_dest_port), .s_length(s_length),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tuser(s_tuser), .s_tready(s_tready),
        .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
        .m_ip_dscp(m_ip_dscp), .m_ip_ecn(m_ip_ecn), .m_ip_ttl(m_ip_ttl),
        .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
        .m_source_port(m_source_port), .m_dest_port(m_dest_port),
        .m_length(m_length), .m_checksum(m_checksum),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser),
        .grant(grant), .busy(busy)
    );

    always #4 clk = ~clk;

    typedef struct { int g; logic [31:0] dip; logic [15:0] sp, dp, len; } hdr_t;
    typedef struct { int g; logic [7:0] d; logic l, u; int cyc; } beat_t;
    typedef struct { int src; int fc; int len; bit ul; } frm_t;

    hdr_t  hq[$];
    beat_t bq[$];
    frm_t  eq[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0, hs_cyc = 0, rdy1_cyc = -1;
    int iso_viol = 0, hdr_chg = 0, hstall = 0;
    bit prev_mhv = 1'b0, prev_rdy1 = 1'b0, toggle = 1'b0;
    logic [79:0] snap;

    int s_nfr[N], s_fc[N], s_idx[N], s_len[N];
    bit s_ph[N], s_ul[N];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dip_of(input int i);
        return (i == 0) ? 32'hC0A80181 : 32'hC0A80102;
    endfunction
    function automatic logic [15:0] dport_of(input int i);
        return (i == 0) ? 16'd1234 : 16'd80;
    endfunction
    function automatic logic [15:0] sport_of(input int i);
        return (i == 0) ? 16'd5000 : 16'd6000;
    endfunction
    function automatic logic [7:0] data_of(input int i, input int fc, input int idx);
        return 8'(i * 128 + fc * 32 + idx);
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bit act;
            bit lst;
            act = (s_fc[i] < s_nfr[i]);
            lst = (s_idx[i] == s_len[i] - 1);
            s_hdr_valid[i]            = act && !s_ph[i];
            s_tvalid[i]               = act && s_ph[i];
            s_tlast[i]                = lst;
            s_tuser[i]                = s_ul[i] && lst;
            s_tdata[i*8 +: 8]         = data_of(i, s_fc[i], s_idx[i]);
            s_dest_ip[i*32 +: 32]     = dip_of(i);
            s_dest_port[i*16 +: 16]   = dport_of(i);
            s_source_port[i*16 +: 16] = sport_of(i);
            s_length[i*16 +: 16]      = 16'(s_len[i]);
        end
        m_hdr_ready = (hstall == 0);
    endtask

    task automatic src_reset();
        for (int i = 0; i < N; i++) begin
            s_nfr[i] = 0; s_fc[i] = 0; s_idx[i] = 0; s_len[i] = 1;
            s_ph[i] = 1'b0; s_ul[i] = 1'b0;
        end
    endtask

    task automatic start_src(input int i, input int nfr, input int len, input bit ul);
        s_nfr[i] = nfr; s_fc[i] = 0; s_idx[i] = 0; s_len[i] = len;
        s_ph[i] = 1'b0; s_ul[i] = ul;
        drive();
    endtask

    // One clock: observe at the falling edge, then update the source models.
    task automatic tick();
        logic [N-1:0] fh, fd, oh;
        bit dec;
        @(negedge clk);
        cyc++;
        fh = s_hdr_valid & s_hdr_ready;
        fd = s_tvalid & s_tready;
        if (fh != '0) hs_cyc = cyc;
        if (m_hdr_valid && !prev_mhv) check_eq("hdr_latency", 64'(cyc - hs_cyc), 64'd1);
        if (m_hdr_valid && prev_mhv && {m_ip_dest_ip, m_dest_port, m_source_port, m_length} != snap)
            hdr_chg++;
        snap     = {m_ip_dest_ip, m_dest_port, m_source_port, m_length};
        prev_mhv = m_hdr_valid;
        if (m_hdr_valid && m_hdr_ready)
            hq.push_back('{int'(grant), m_ip_dest_ip, m_source_port, m_dest_port, m_length});
        if (m_tvalid && m_tready)
            bq.push_back('{int'(grant), m_tdata, m_tlast, m_tuser, cyc});
        oh = N'(1) << grant;
        if ((s_tready & ~oh) != '0) iso_viol++;
        if (busy && s_hdr_ready != '0) iso_viol++;
        if ($countones(s_hdr_ready) > 1) iso_viol++;
        if (s_hdr_ready[1] && !prev_rdy1) rdy1_cyc = cyc;
        prev_rdy1 = s_hdr_ready[1];
        dec = m_hdr_valid && (hstall > 0);

        @(posedge clk);
        #1;
        if (rst) begin
            src_reset();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (fh[i]) begin
                    s_ph[i] = 1'b1; s_idx[i] = 0;
                end else if (fd[i]) begin
                    if (s_idx[i] == s_len[i] - 1) begin
                        s_ph[i] = 1'b0; s_idx[i] = 0; s_fc[i]++;
                    end else begin
                        s_idx[i]++;
                    end
                end
            end
        end
        if (dec) hstall--;
        m_tready = toggle ? ~m_tready : 1'b1;
        drive();
    endtask

    task automatic run(input int bound);
        int n;
        bit act;
        n = 0;
        act = 1'b1;
        while ((act || busy) && n < bound) begin
            tick();
            n++;
            act = 1'b0;
            for (int i = 0; i < N; i++) if (s_fc[i] < s_nfr[i]) act = 1'b1;
        end
        check_eq("run_done", 64'(n < bound), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hstall = 0; toggle = 1'b0; m_tready = 1'b1;
        src_reset();
        drive();
        tick();
        tick();
        rst = 1'b0;
        hq.delete(); bq.delete(); eq.delete();
        prev_rdy1 = 1'b0; rdy1_cyc = -1; iso_viol = 0; hdr_chg = 0;
    endtask

    task automatic verify(input string tag);
        int p, errs, nb;
        p = 0; errs = 0; nb = 0;
        foreach (eq[k]) nb += eq[k].len;
        check_eq({tag, "_nhdr"}, 64'(hq.size()), 64'(eq.size()));
        check_eq({tag, "_nbeats"}, 64'(bq.size()), 64'(nb));
        foreach (eq[k]) begin
            if (k < hq.size()) begin
                check_eq({tag, "_grant"}, 64'(hq[k].g), 64'(eq[k].src));
                check_eq({tag, "_dip"}, 64'(hq[k].dip), 64'(dip_of(eq[k].src)));
                check_eq({tag, "_ports_len"}, 64'({hq[k].dp, hq[k].sp, hq[k].len}),
                         64'({dport_of(eq[k].src), sport_of(eq[k].src), 16'(eq[k].len)}));
            end
            for (int j = 0; j < eq[k].len; j++) begin
                if (p >= bq.size()) errs++;
                else if (bq[p].d !== data_of(eq[k].src, eq[k].fc, j) ||
                         bq[p].l !== (j == eq[k].len - 1) ||
                         bq[p].u !== (eq[k].ul && j == eq[k].len - 1) ||
                         bq[p].g != eq[k].src) errs++;
                p++;
            end
        end
        check_eq({tag, "_beat_errs"}, 64'(errs), 64'd0);
    endtask

    initial begin
        s_hdr_valid = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0; s_tdata = '0;
        s_dest_ip = '0; s_source_port = '0; s_dest_port = '0; s_length = '0;
        m_hdr_ready = 1'b1; m_tready = 1'b1;
        do_reset();

        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_hdr_valid", 64'(m_hdr_valid), 64'd0);
        check_eq("rst_grant", 64'(grant), 64'd0);
        check_eq("rst_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("rst_dest_ip", 64'(m_ip_dest_ip), 64'd0);
        check_eq("rst_ttl", 64'(m_ip_ttl), 64'd64);
        check_eq("rst_src_ip", 64'(m_ip_source_ip), 64'hC0A80164);
        check_eq("rst_consts", 64'({m_ip_dscp, m_ip_ecn, m_checksum}), 64'd0);
        check_eq("rst_ready", 64'({s_hdr_ready, s_tready}), 64'd0);

        // single source, 10-byte frame
        start_src(0, 1, 10, 1'b0);
        eq.push_back('{0, 0, 10, 1'b0});
        run(200);
        verify("t1");

        // contention: both sources, three frames each
        do_reset();
        start_src(0, 3, 4, 1'b0);
        start_src(1, 3, 5, 1'b0);
        for (int f = 0; f < 3; f++) begin
            eq.push_back('{0, f, 4, 1'b0});
            eq.push_back('{1, f, 5, 1'b0});
        end
        run(400);
        verify("t2");
        check_eq("t2_isolation", 64'(iso_viol), 64'd0);

        // header stall then toggling payload ready
        do_reset();
        hstall = 5; toggle = 1'b1;
        start_src(0, 1, 8, 1'b0);
        start_src(1, 1, 3, 1'b0);
        eq.push_back('{0, 0, 8, 1'b0});
        eq.push_back('{1, 0, 3, 1'b0});
        run(300);
        verify("t3");
        check_eq("t3_stall_used", 64'(hstall), 64'd0);
        check_eq("t3_hdr_stable", 64'(hdr_chg), 64'd0);
        check_eq("t3_isolation", 64'(iso_viol), 64'd0);

        // reset during payload beat 4 of a 20-byte frame from source 1
        do_reset();
        start_src(1, 1, 20, 1'b0);
        begin
            int n;
            n = 0;
            while (!(s_ph[1] && s_idx[1] == 3) && n < 100) begin
                tick();
                n++;
            end
            check_eq("t4_reach_beat4", 64'(n < 100), 64'd1);
        end
        check_eq("t4_grant_before", 64'(grant), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t4_beats_before", 64'(bq.size()), 64'd4);
        check_eq("t4_busy", 64'(busy), 64'd0);
        check_eq("t4_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("t4_hdr_valid", 64'(m_hdr_valid), 64'd0);
        check_eq("t4_grant", 64'(grant), 64'd0);
        hq.delete(); bq.delete(); eq.delete();
        start_src(1, 1, 6, 1'b0);
        eq.push_back('{1, 0, 6, 1'b0});
        run(200);
        verify("t4");

        // tuser on last beat and re-arbitration gap
        do_reset();
        start_src(0, 1, 3, 1'b1);
        start_src(1, 1, 2, 1'b0);
        eq.push_back('{0, 0, 3, 1'b1});
        eq.push_back('{1, 0, 2, 1'b0});
        run(200);
        verify("t5");
        if (bq.size() >= 3) begin
            check_eq("t5_tuser_last", 64'(bq[2].u), 64'd1);
            check_eq("t5_gap", 64'(rdy1_cyc), 64'(bq[2].cyc + 1));
        end else begin
            check_eq("t5_beats_present", 64'(bq.size()), 64'd3);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
